// File: rtl/pq_driver.sv
// Initiator-side driver for a pipelined max-first tree priority queue: arbitrates push/pop
// into enq/deq requests and buffers dequeued values. Optional counters: PQ_DRIVER_STATS_EN.
module pq_driver #(
  parameter int L = 3,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_value,
  output logic         in_ready,
  input  logic         pop_req,
  output logic         out_valid,
  output logic [W-1:0] out_value,
  input  logic         out_ready,
  output logic         pq_enq_valid,
  output logic [W-1:0] pq_enq_value,
  input  logic         pq_enq_ready,
  output logic         pq_deq_req,
  input  logic [W-1:0] pq_deq_value,
  input  logic         pq_deq_valid,
  output logic [L:0]   count,
  output logic         underflow_err
`ifdef PQ_DRIVER_STATS_EN
  ,
  output logic [15:0]  stat_enq,
  output logic [15:0]  stat_deq
`endif
);

  localparam int CAP_I = (1 << L) - 1;
  localparam logic [L:0] CAP = CAP_I[L:0];
  localparam logic [L:0] ONE = {{L{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ENQ_COOL, DEQ_WAIT} state_t;

  state_t         state_q, state_d;
  logic [L:0]     count_q;
  logic           last_deq_q;
  logic           underflow_q;
  logic [W-1:0]   fifo_mem [2];
  logic           rd_ptr, wr_ptr;
  logic [1:0]     fifo_cnt;

  logic push_ok, pop_ok, grant_enq, grant_deq, capture, out_pop;

  always_comb begin
    push_ok   = in_valid && pq_enq_ready && (count_q < CAP);
    pop_ok    = pop_req && (count_q != '0) && (fifo_cnt < 2'd2);
    grant_enq = 1'b0;
    grant_deq = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        // Contested cycle: grant whichever side lost last time
        if (!rst && push_ok && (!pop_ok || last_deq_q)) begin
          grant_enq = 1'b1;
          state_d   = ENQ_COOL;
        end else if (!rst && pop_ok) begin
          grant_deq = 1'b1;
          state_d   = DEQ_WAIT;
        end
      end
      ENQ_COOL: state_d = IDLE;
      DEQ_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign capture      = (state_q == DEQ_WAIT) && pq_deq_valid && !rst;
  assign out_valid    = (fifo_cnt != 2'd0) && !rst;
  assign out_pop      = out_valid && out_ready;
  assign out_value    = out_valid ? fifo_mem[rd_ptr] : '0;
  assign in_ready     = grant_enq;
  assign pq_enq_valid = grant_enq;
  assign pq_enq_value = grant_enq ? in_value : '0;
  assign pq_deq_req   = grant_deq;
  assign count        = count_q;
  assign underflow_err = underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      last_deq_q  <= 1'b1;
      underflow_q <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state_q <= state_d;
      if (grant_enq || grant_deq)
        last_deq_q <= grant_deq;
      if (grant_enq)
        count_q <= count_q + ONE;
      else if (capture)
        count_q <= count_q - ONE;
      // A missing response leaves count alone; the queue state is unknown
      if (state_q == DEQ_WAIT && !pq_deq_valid)
        underflow_q <= 1'b1;
      if (capture) begin
        fifo_mem[wr_ptr] <= pq_deq_value;
        wr_ptr           <= ~wr_ptr;
      end
      if (out_pop)
        rd_ptr <= ~rd_ptr;
      case ({capture, out_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef PQ_DRIVER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_enq <= 16'd0;
      stat_deq <= 16'd0;
    end else begin
      if (grant_enq) stat_enq <= stat_enq + 16'd1;
      if (capture)   stat_deq <= stat_deq + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pq_driver.sv
// Directed bench for pq_driver with a behavioural max-first queue stub.
module tb_pq_driver;
  localparam int L = 3;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, pop_req, out_valid, out_ready;
  logic [W-1:0] in_value, out_value, pq_enq_value, pq_deq_value;
  logic         pq_enq_valid, pq_enq_ready, pq_deq_req, pq_deq_valid;
  logic [L:0]   count;
  logic         underflow_err;
`ifdef PQ_DRIVER_STATS_EN
  logic [15:0]  stat_enq, stat_deq;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic drop_resp = 1'b0;
  logic [W-1:0] sq [$];
  int mi;

  logic [W-1:0] vals [8] = '{32'd4, 32'd44, 32'd444, 32'd4444, 32'd44444,
                             32'd444444, 32'd4444444, 32'd99};
  int cnt_alt [8] = '{3, 3, 2, 3, 3, 3, 2, 3};
  int cnt_hold [8] = '{5, 5, 4, 4, 3, 3, 3, 3};

  always #5 clk = ~clk;

  pq_driver #(.L(L), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
    .pop_req(pop_req), .out_valid(out_valid), .out_value(out_value), .out_ready(out_ready),
    .pq_enq_valid(pq_enq_valid), .pq_enq_value(pq_enq_value), .pq_enq_ready(pq_enq_ready),
    .pq_deq_req(pq_deq_req), .pq_deq_value(pq_deq_value), .pq_deq_valid(pq_deq_valid),
    .count(count), .underflow_err(underflow_err)
`ifdef PQ_DRIVER_STATS_EN
    , .stat_enq(stat_enq), .stat_deq(stat_deq)
`endif
  );

  // Queue stub: responds one cycle after deq_req with the current maximum
  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      pq_deq_valid <= 1'b0;
      pq_deq_value <= '0;
    end else begin
      pq_deq_valid <= 1'b0;
      if (pq_enq_valid) sq.push_back(pq_enq_value);
      if (pq_deq_req && !drop_resp && sq.size() > 0) begin
        mi = 0;
        for (int i = 1; i < sq.size(); i++)
          if (sq[i] > sq[mi]) mi = i;
        pq_deq_value <= sq[mi];
        pq_deq_valid <= 1'b1;
        sq.delete(mi);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int pi;
    rst = 1'b1; in_valid = 1'b0; in_value = '0; pop_req = 1'b0; out_ready = 1'b0;
    pq_enq_ready = 1'b1;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_underflow", underflow_err, 0);
    chk("rst_deq_req", pq_deq_req, 0);
    chk("rst_enq_valid", pq_enq_valid, 0);
    rst = 1'b0;

    // Fill to capacity; eighth push is held
    pi = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_value = vals[pi];
      #1;
      chk("fill_ready", in_ready, (c % 2 == 0) && (c < 14));
      chk("fill_count", count, (c + 1) / 2);
      if (in_ready) begin
        chk("fill_enq_value", pq_enq_value, vals[pi]);
        pi++;
      end
    end

    // Drain: values come out largest first, then pop_req is ignored at empty
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      in_valid = 1'b0; pop_req = 1'b1; out_ready = 1'b1;
      #1;
      chk("drain_deq_req", pq_deq_req, (c % 2 == 0) && (c < 14));
      chk("drain_out_valid", out_valid, (c % 2 == 0) && (c >= 2) && (c <= 14));
      if ((c % 2 == 0) && (c >= 2) && (c <= 14))
        chk("drain_out_value", out_value, vals[7 - c / 2]);
      chk("drain_count", count, (c > 14) ? 0 : 7 - c / 2);
    end

    // Preload 100,200,300
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pop_req = 1'b0; in_valid = 1'b1;
      in_value = 32'd100 * (c / 2 + 1);
      #1;
      chk("pre_ready", in_ready, c % 2 == 0);
    end

    // Contested push/pop alternates, starting with DEQ after the ENQ run
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1'b1; pop_req = 1'b1; out_ready = 1'b1;
      in_value = (c < 4) ? 32'd10 : 32'd20;
      #1;
      chk("alt_deq_req", pq_deq_req, c % 4 == 0);
      chk("alt_in_ready", in_ready, c % 4 == 2);
      chk("alt_excl", pq_enq_valid && pq_deq_req, 0);
      chk("alt_count", count, cnt_alt[c]);
      if (c == 2) chk("alt_out_value0", out_value, 300);
      if (c == 6) chk("alt_out_value1", out_value, 200);
    end

    // Top up to 5: add 50, 60
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pop_req = 1'b0; in_valid = 1'b1;
      in_value = (c < 2) ? 32'd50 : 32'd60;
      #1;
      chk("top_ready", in_ready, c % 2 == 0);
    end

    // Stalled downstream: only two deqs fit in the FIFO
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = 1'b0; pop_req = 1'b1; out_ready = 1'b0;
      #1;
      chk("hold_deq_req", pq_deq_req, (c == 0) || (c == 2));
      chk("hold_count", count, cnt_hold[c]);
      if (c >= 2) chk("hold_out_valid", out_valid, 1);
    end
    chk("hold_head", out_value, 100);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pop_req = 1'b0; out_ready = 1'b1;
      #1;
      chk("unload_valid", out_valid, c < 2);
      if (c == 0) chk("unload_v0", out_value, 100);
      if (c == 1) chk("unload_v1", out_value, 60);
      chk("unload_deq_req", pq_deq_req, 0);
    end

    // Missing deq response
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drop_resp = 1'b1; pop_req = (c == 0); out_ready = 1'b1;
      #1;
      if (c == 0) chk("uf_deq_req", pq_deq_req, 1);
      chk("uf_err", underflow_err, c >= 2);
      if (c >= 2) begin
        chk("uf_count", count, 3);
        chk("uf_out_valid", out_valid, 0);
      end
    end
    drop_resp = 1'b0;

`ifdef PQ_DRIVER_STATS_EN
    chk("stat_enq", stat_enq, 14);
    chk("stat_deq", stat_deq, 11);
`endif

    // Reset while a deq is in flight
    @(negedge clk);
    pop_req = 1'b1; #1;
    chk("rd_deq_req", pq_deq_req, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rd_hold_deq", pq_deq_req, 0);
    @(negedge clk);
    #1;
    chk("rd_count", count, 0);
    chk("rd_out_valid", out_valid, 0);
    chk("rd_underflow", underflow_err, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_value = 32'd7; #1;
    chk("rd_idle_ready", in_ready, 1);
    chk("rd_idle_deq", pq_deq_req, 0);
    chk("rd_count2", count, 0);
    chk("rd_out_valid2", out_valid, 0);
`ifdef PQ_DRIVER_STATS_EN
    chk("rd_stat_enq", stat_enq, 0);
    chk("rd_stat_deq", stat_deq, 0);
`endif
    @(negedge clk);
    in_valid = 1'b0; pop_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pq_driver.md
Name: pq_driver

Overview:
- Initiator-side controller for the pipelined tree priority queue (max-first, 2^L-1 entries).
- Converts an upstream push stream and a downstream pop stream into the queue's enq/deq request protocol.
- Never presents enq and deq in the same cycle. Tracks occupancy and respects the queue's one-cycle root-busy window after every operation.
- Buffers dequeued values in a 2-entry output FIFO.

Parameters:
L, 3, tree levels of the attached queue; capacity CAP = 2^L-1
W, 32, value width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; the attached queue is held in reset in the same cycles
in_valid  in  1  push request
in_value  in  W  push value
in_ready  out  1  push accepted when in_valid && in_ready
pop_req  in  1  level: downstream wants values dequeued
out_valid  out  1  dequeued value available
out_value  out  W  dequeued value (FIFO head)
out_ready  in  1  downstream consumes when out_valid && out_ready
pq_enq_valid  out  1  to queue enq_valid
pq_enq_value  out  W  to queue enq_value
pq_enq_ready  in  1  from queue enq_ready
pq_deq_req  out  1  to queue deq_req
pq_deq_value  in  W  from queue deq_value
pq_deq_valid  in  1  from queue deq_valid
count  out  L+1  queue occupancy as tracked by driver
underflow_err  out  1  sticky: deq response missing

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, count=0, FIFO empty, last_grant=DEQ, underflow_err=0. All outputs 0 during and after reset; out_value=0.
- FSM states: IDLE, ENQ_COOL, DEQ_WAIT.
- Eligibility in IDLE:
  - push_ok = in_valid && pq_enq_ready && count<CAP
  - pop_ok = pop_req && count>0 && fifo_cnt<2
- Grant: if only one of push_ok/pop_ok holds, grant it. If both hold, grant the opposite of last_grant (round-robin). last_grant updates on every grant.
- ENQ grant (IDLE only):
  - Combinationally drive pq_enq_valid=1, pq_enq_value=in_value, in_ready=1.
  - At the edge: count+1, state -> ENQ_COOL.
- ENQ_COOL: the queue root is busy. Drive nothing, in_ready=0; next state IDLE.
- DEQ grant (IDLE only): pq_deq_req=1 for exactly this cycle; state -> DEQ_WAIT.
- DEQ_WAIT:
  - If pq_deq_valid=1: push pq_deq_value into the FIFO, count-1.
  - Else: set underflow_err=1 and leave count unchanged.
  - In both cases next state is IDLE.
- Throughput: at most one queue operation per 2 cycles. Push-to-ready-again latency is 2 cycles. Pop issue-to-out_valid latency is 2 cycles when the FIFO was empty (issue cycle, capture edge at end of DEQ_WAIT, visible next cycle).
- in_ready=0 and pq_enq_valid=0 in every cycle except an ENQ grant. pq_deq_req=0 except a DEQ grant. All three are never 1 together.
- FIFO (2 entries, first-word-fall-through): out_valid = fifo_cnt>0. A capture and an out handshake in the same cycle are both honoured, so fifo_cnt stays the same.
- Full boundary: count==CAP blocks push even if pq_enq_ready=1.
- Empty boundary: count==0 blocks pop; pop_req is ignored.
- The FIFO-full check happens at issue. A DEQ is only issued with fifo_cnt<=1 and only one DEQ is in flight, so capture never overflows.
- Reset mid-operation (including DEQ_WAIT): the in-flight op is dropped, all state clears, and no capture occurs.

Optional Feature:
PQ_DRIVER_STATS_EN
- Defined: adds outputs stat_enq[15:0] and stat_deq[15:0]. They count completed ENQ grants and successful DEQ captures, wrap modulo 2^16, and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Push 4, 44, 444, 4444, 44444, 444444, 4444444 back-to-back, pop_req=0 -> in_ready pulses every 2nd cycle, count reaches 7, 8th push held (in_ready=0).
- From full, pop_req=1, out_ready=1 -> out_value sequence 4444444, 444444, …, 4; count reaches 0; pop_req then ignored, pq_deq_req stays 0.
- in_valid=1 and pop_req=1 continuously with count=3 -> grants alternate ENQ/DEQ, pq_enq_valid and pq_deq_req never high in the same cycle.
- out_ready=0, pop_req=1, count=5 -> exactly 2 deqs issued, out_valid=1, fifo holds two largest, count=3; no further pq_deq_req until out_ready.
- Stub queue returns pq_deq_valid=0 in DEQ_WAIT -> underflow_err=1 sticky, count unchanged, FIFO unchanged.
- Assert rst in DEQ_WAIT -> next cycle count=0, out_valid=0, underflow_err=0, state IDLE; with PQ_DRIVER_STATS_EN, stat_enq=stat_deq=0.
